// File: rtl/i_cache_nway_if.sv
// CPU request/response and memory refill handshake bundle for i_cache_nway.
// slave = cache side, master = CPU/memory environment side.
interface i_cache_nway_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADD_WIDTH  = 12
);
  logic                  cpu_req;
  logic                  cpu_wren;
  logic [ADD_WIDTH-1:0]  cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_din;
  logic                  cpu_ready;
  logic                  cpu_valid;
  logic                  cpu_hit_miss;
  logic [DATA_WIDTH-1:0] cpu_data_out;

  logic                  mem_req;
  logic                  mem_wren;
  logic [ADD_WIDTH-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic [DATA_WIDTH-1:0] mem_din;
  logic                  mem_ack;

  modport slave (
    input  cpu_req, cpu_wren, cpu_addr, cpu_din, mem_din, mem_ack,
    output cpu_ready, cpu_valid, cpu_hit_miss, cpu_data_out,
           mem_req, mem_wren, mem_addr, mem_dout
  );

  modport master (
    output cpu_req, cpu_wren, cpu_addr, cpu_din, mem_din, mem_ack,
    input  cpu_ready, cpu_valid, cpu_hit_miss, cpu_data_out,
           mem_req, mem_wren, mem_addr, mem_dout
  );
endinterface

// File: rtl/i_cache_nway.sv
// N-way set-associative instruction cache, multi-word lines, age-based LRU,
// write-through / no-write-allocate. Define I_CACHE_PERF_CNT_EN for hit/miss counters.
module i_cache_nway #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADD_WIDTH  = 12,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 16,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  i_cache_nway_if.slave        bus,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned AGE_W = $clog2(WAYS);
  localparam int unsigned TAG_W = ADD_WIDTH - IDX_W - OFF_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, WRITE_MEM, RESP} state_e;

  state_e                state_q, state_d;
  logic [ADD_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  wren_q, wren_d;
  logic                  hit_q, hit_d;
  logic [AGE_W-1:0]      way_q, way_d;
  logic [OFF_W-1:0]      cnt_q, cnt_d;

  logic                  cpu_ready_q, cpu_ready_d;
  logic                  cpu_valid_q, cpu_valid_d;
  logic                  cpu_hit_miss_q, cpu_hit_miss_d;
  logic [DATA_WIDTH-1:0] cpu_data_q, cpu_data_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_wren_q, mem_wren_d;
  logic [ADD_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_dout_q, mem_dout_d;

  logic [TAG_W-1:0]      tag_q [SETS][WAYS];
  logic [TAG_W-1:0]      tag_d [SETS][WAYS];
  logic [WAYS-1:0]       valid_q [SETS];
  logic [WAYS-1:0]       valid_d [SETS];
  logic [AGE_W-1:0]      age_q [SETS][WAYS];
  logic [AGE_W-1:0]      age_d [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_mem [SETS][WAYS][LINE_WORDS];

  logic [TAG_W-1:0]      tag_c;
  logic [IDX_W-1:0]      idx_c;
  logic [OFF_W-1:0]      off_c;
  logic                  hit_c;
  logic [AGE_W-1:0]      hit_way_c;
  logic [AGE_W-1:0]      victim_c;

  logic                  data_we;
  logic [OFF_W-1:0]      data_off;
  logic [DATA_WIDTH-1:0] data_wdata;
  logic                  touch_en;
  logic [AGE_W-1:0]      touch_way;

  assign tag_c = addr_q[ADD_WIDTH-1 -: TAG_W];
  assign idx_c = addr_q[OFF_W +: IDX_W];
  assign off_c = addr_q[OFF_W-1:0];

  // Tag match and victim choice for the registered request's set
  always_comb begin
    hit_c     = 1'b0;
    hit_way_c = '0;
    victim_c  = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[idx_c][w] && (tag_q[idx_c][w] == tag_c)) begin
        hit_c     = 1'b1;
        hit_way_c = AGE_W'(w);
      end
      if (age_q[idx_c][w] == AGE_W'(WAYS - 1)) begin
        victim_c = AGE_W'(w);
      end
    end
    // an invalid way beats the oldest one; scanning downwards leaves the lowest
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (!valid_q[idx_c][i]) begin
        victim_c = AGE_W'(i);
      end
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    din_d          = din_q;
    wren_d         = wren_q;
    hit_d          = hit_q;
    way_d          = way_q;
    cnt_d          = cnt_q;
    cpu_valid_d    = 1'b0;
    cpu_hit_miss_d = cpu_hit_miss_q;
    cpu_data_d     = cpu_data_q;
    mem_req_d      = mem_req_q;
    mem_wren_d     = mem_wren_q;
    mem_addr_d     = mem_addr_q;
    mem_dout_d     = mem_dout_q;
    tag_d          = tag_q;
    valid_d        = valid_q;
    age_d          = age_q;
    data_we        = 1'b0;
    data_off       = off_c;
    data_wdata     = din_q;
    touch_en       = 1'b0;
    touch_way      = way_q;

    case (state_q)
      IDLE: begin
        if (bus.cpu_req && cpu_ready_q) begin
          addr_d  = bus.cpu_addr;
          din_d   = bus.cpu_din;
          wren_d  = bus.cpu_wren;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        hit_d = hit_c;
        if (wren_q) begin
          way_d      = hit_way_c;
          mem_req_d  = 1'b1;
          mem_wren_d = 1'b1;
          mem_addr_d = addr_q;
          mem_dout_d = din_q;
          state_d    = WRITE_MEM;
        end else if (hit_c) begin
          cpu_data_d     = data_mem[idx_c][hit_way_c][off_c];
          cpu_valid_d    = 1'b1;
          cpu_hit_miss_d = 1'b1;
          touch_en       = 1'b1;
          touch_way      = hit_way_c;
          state_d        = IDLE;
        end else begin
          way_d      = victim_c;
          cnt_d      = '0;
          mem_req_d  = 1'b1;
          mem_wren_d = 1'b0;
          mem_addr_d = {tag_c, idx_c, {OFF_W{1'b0}}};
          state_d    = REFILL;
        end
      end
      REFILL: begin
        if (mem_req_q && bus.mem_ack) begin
          data_we    = 1'b1;
          data_off   = cnt_q;
          data_wdata = bus.mem_din;
          mem_req_d  = 1'b0;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == OFF_W'(LINE_WORDS - 1)) begin
            tag_d[idx_c][way_q]   = tag_c;
            valid_d[idx_c][way_q] = 1'b1;
            touch_en              = 1'b1;
            // the requested word is either this beat or already in the array
            cpu_data_d     = (cnt_q == off_c) ? bus.mem_din : data_mem[idx_c][way_q][off_c];
            cpu_valid_d    = 1'b1;
            cpu_hit_miss_d = 1'b0;
            state_d        = RESP;
          end
        end else if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_addr_d = {tag_c, idx_c, cnt_q};
        end
      end
      WRITE_MEM: begin
        if (mem_req_q && bus.mem_ack) begin
          mem_req_d  = 1'b0;
          mem_wren_d = 1'b0;
          if (hit_q) begin
            data_we  = 1'b1;
            touch_en = 1'b1;
          end
          cpu_valid_d    = 1'b1;
          cpu_hit_miss_d = hit_q;
          state_d        = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // touched way becomes youngest, ways younger than it age by one
    if (touch_en) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (AGE_W'(w) == touch_way) begin
          age_d[idx_c][w] = '0;
        end else if (age_q[idx_c][w] < age_q[idx_c][touch_way]) begin
          age_d[idx_c][w] = age_q[idx_c][w] + 1'b1;
        end
      end
    end

    cpu_ready_d = (state_d == IDLE) && !cpu_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      din_q          <= '0;
      wren_q         <= 1'b0;
      hit_q          <= 1'b0;
      way_q          <= '0;
      cnt_q          <= '0;
      cpu_ready_q    <= 1'b0;
      cpu_valid_q    <= 1'b0;
      cpu_hit_miss_q <= 1'b0;
      cpu_data_q     <= '0;
      mem_req_q      <= 1'b0;
      mem_wren_q     <= 1'b0;
      mem_addr_q     <= '0;
      mem_dout_q     <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      din_q          <= din_d;
      wren_q         <= wren_d;
      hit_q          <= hit_d;
      way_q          <= way_d;
      cnt_q          <= cnt_d;
      cpu_ready_q    <= cpu_ready_d;
      cpu_valid_q    <= cpu_valid_d;
      cpu_hit_miss_q <= cpu_hit_miss_d;
      cpu_data_q     <= cpu_data_d;
      mem_req_q      <= mem_req_d;
      mem_wren_q     <= mem_wren_d;
      mem_addr_q     <= mem_addr_d;
      mem_dout_q     <= mem_dout_d;
    end
  end

  // Tag, valid and age state; a reset mid-refill leaves the line invalid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
          tag_q[s][w] <= '0;
          age_q[s][w] <= AGE_W'(w);
        end
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      age_q   <= age_d;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) begin
      data_mem[idx_c][way_q][data_off] <= data_wdata;
    end
  end

`ifdef I_CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Saturating response counters
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (cpu_valid_q) begin
      if (cpu_hit_miss_q && (hit_cnt_q != 32'hFFFF_FFFF)) begin
        hit_cnt_d = hit_cnt_q + 32'd1;
      end
      if (!cpu_hit_miss_q && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

  assign bus.cpu_ready    = cpu_ready_q;
  assign bus.cpu_valid    = cpu_valid_q;
  assign bus.cpu_hit_miss = cpu_hit_miss_q;
  assign bus.cpu_data_out = cpu_data_q;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_wren     = mem_wren_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_dout     = mem_dout_q;

endmodule

// File: tb/tb_i_cache_nway.sv
// Scoreboard bench for i_cache_nway: expected responses and memory transfers are
// queued when a request is driven and retired as the cache and memory model see them.
module tb_i_cache_nway;

  typedef struct packed {
    logic        hit;
    logic [31:0] data;
  } resp_t;

  typedef struct packed {
    logic        wren;
    logic [11:0] addr;
    logic [31:0] data;
  } xfer_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  i_cache_nway_if #(.DATA_WIDTH(32), .ADD_WIDTH(12)) bus ();

  i_cache_nway dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          acc_cyc  = 0;
  int          resp_cyc = 0;
  int          resp_cnt = 0;
  int          ack_delay = 0;
  int          gap_bad  = 0;
  int          exp_hits = 0;
  int          exp_misses = 0;
  logic [31:0] exp_dout = '0;
  resp_t       exp_resp_q[$];
  xfer_t       exp_mem_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model: data = address, ack after ack_delay cycles of mem_req
  initial begin
    int    wait_cnt = 0;
    xfer_t e;
    xfer_t g;
    bus.mem_ack = 1'b0;
    bus.mem_din = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_ack) begin
        if (bus.mem_req) gap_bad++;
        bus.mem_ack = 1'b0;
        wait_cnt = 0;
      end else if (bus.mem_req && rst_n) begin
        if (wait_cnt >= ack_delay) begin
          bus.mem_ack = 1'b1;
          bus.mem_din = 32'(bus.mem_addr);
          g.wren = bus.mem_wren;
          g.addr = bus.mem_addr;
          g.data = bus.mem_wren ? bus.mem_dout : 32'h0;
          check_eq("mem_pending", 64'(exp_mem_q.size() > 0), 64'd1);
          if (exp_mem_q.size() > 0) begin
            e = exp_mem_q.pop_front();
            check_eq("mem_xfer", 64'(g), 64'(e));
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Response monitor
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.cpu_valid) begin
        resp_cnt++;
        resp_cyc = cyc;
        check_eq("resp_pending", 64'(exp_resp_q.size() > 0), 64'd1);
        if (exp_resp_q.size() > 0) begin
          e = exp_resp_q.pop_front();
          check_eq("resp_hit", 64'(bus.cpu_hit_miss), 64'(e.hit));
          check_eq("resp_data", 64'(bus.cpu_data_out), 64'(e.data));
        end
      end
    end
  end

  task automatic push_exp(input logic wren, input logic [11:0] addr, input logic [31:0] din,
                          input logic hit, input logic [31:0] rdata);
    resp_t r;
    xfer_t x;
    if (wren) begin
      x.wren = 1'b1; x.addr = addr; x.data = din;
      exp_mem_q.push_back(x);
    end else if (!hit) begin
      for (int k = 0; k < 4; k++) begin
        x.wren = 1'b0; x.addr = {addr[11:2], 2'(k)}; x.data = 32'h0;
        exp_mem_q.push_back(x);
      end
    end
    if (!wren) exp_dout = rdata;
    r.hit  = hit;
    r.data = exp_dout;
    exp_resp_q.push_back(r);
    if (hit) exp_hits++; else exp_misses++;
  endtask

  task automatic issue(input logic wren, input logic [11:0] addr, input logic [31:0] din);
    int n = 0;
    bus.cpu_req  = 1'b1;
    bus.cpu_wren = wren;
    bus.cpu_addr = addr;
    bus.cpu_din  = din;
    while (!bus.cpu_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check_eq("accept", 64'(bus.cpu_ready), 64'd1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    bus.cpu_req = 1'b0;
  endtask

  task automatic await_resp(output int lat);
    int start = resp_cnt;
    int n = 0;
    while (resp_cnt == start && n < 500) begin
      @(posedge clk); #1; n++;
    end
    check_eq("resp_seen", 64'(resp_cnt != start), 64'd1);
    lat = resp_cyc - acc_cyc + 1;
  endtask

  task automatic do_access(input logic wren, input logic [11:0] addr, input logic [31:0] din,
                           input logic hit, input logic [31:0] rdata);
    int lat;
    push_exp(wren, addr, din, hit, rdata);
    issue(wren, addr, din);
    await_resp(lat);
    if (hit && !wren) check_eq("hit_latency", 64'(lat), 64'd2);
  endtask

  task automatic reset_checks(input string pfx);
    check_eq({pfx, "_ready"},   64'(bus.cpu_ready), 64'd0);
    check_eq({pfx, "_valid"},   64'(bus.cpu_valid), 64'd0);
    check_eq({pfx, "_hitmiss"}, 64'(bus.cpu_hit_miss), 64'd0);
    check_eq({pfx, "_dout"},    64'(bus.cpu_data_out), 64'd0);
    check_eq({pfx, "_mreq"},    64'(bus.mem_req), 64'd0);
    check_eq({pfx, "_mwren"},   64'(bus.mem_wren), 64'd0);
    check_eq({pfx, "_maddr"},   64'(bus.mem_addr), 64'd0);
    check_eq({pfx, "_mdout"},   64'(bus.mem_dout), 64'd0);
    check_eq({pfx, "_hitcnt"},  64'(hit_cnt), 64'd0);
    check_eq({pfx, "_misscnt"}, 64'(miss_cnt), 64'd0);
  endtask

  task automatic check_counters();
`ifdef I_CACHE_PERF_CNT_EN
    check_eq("hit_cnt", 64'(hit_cnt), 64'(exp_hits));
    check_eq("miss_cnt", 64'(miss_cnt), 64'(exp_misses));
`else
    check_eq("hit_cnt_tied", 64'(hit_cnt), 64'd0);
    check_eq("miss_cnt_tied", 64'(miss_cnt), 64'd0);
`endif
  endtask

  initial begin
    int n;
    int start;
    int bad;
    int ready_bad;
    logic        have;
    logic [11:0] held;

    clk = 1'b0;
    rst_n = 1'b0;
    bus.cpu_req = 1'b0;
    bus.cpu_wren = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_din = '0;

    #12;
    reset_checks("rst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("ready_after_rst", 64'(bus.cpu_ready), 64'd1);

    // cold fill, re-read hit, write-through hit, read back
    do_access(1'b0, 12'hABC, 32'h0, 1'b0, 32'h0000_0ABC);
    do_access(1'b0, 12'hABC, 32'h0, 1'b1, 32'h0000_0ABC);
    do_access(1'b1, 12'hABC, 32'hBADD_BEEF, 1'b1, 32'h0);
    do_access(1'b0, 12'hABC, 32'h0, 1'b1, 32'hBADD_BEEF);

    // LRU in set 0xF (0xABC already occupies one way)
    do_access(1'b0, 12'h03C, 32'h0, 1'b0, 32'h0000_003C);
    do_access(1'b0, 12'h13C, 32'h0, 1'b0, 32'h0000_013C);
    do_access(1'b0, 12'h03C, 32'h0, 1'b1, 32'h0000_003C);
    do_access(1'b0, 12'h23C, 32'h0, 1'b0, 32'h0000_023C);
    do_access(1'b0, 12'h03C, 32'h0, 1'b1, 32'h0000_003C);
    do_access(1'b0, 12'h13C, 32'h0, 1'b0, 32'h0000_013C);

    // write miss: no allocation
    do_access(1'b1, 12'h500, 32'h1234_5678, 1'b0, 32'h0);
    do_access(1'b0, 12'h500, 32'h0, 1'b0, 32'h0000_0500);

    // stretched acks with a request presented while busy
    push_exp(1'b0, 12'h2C8, 32'h0, 1'b0, 32'h0000_02C8);
    ack_delay = 10;
    issue(1'b0, 12'h2C8, 32'h0);
    bus.cpu_req = 1'b1; bus.cpu_wren = 1'b1; bus.cpu_addr = 12'h111; bus.cpu_din = 32'h1;
    start = resp_cnt; n = 0; bad = 0; ready_bad = 0; have = 1'b0; held = '0;
    while (resp_cnt == start && n < 500) begin
      if (n == 30) begin bus.cpu_req = 1'b0; bus.cpu_wren = 1'b0; end
      if (bus.cpu_ready) ready_bad++;
      if (bus.mem_req && !bus.mem_ack) begin
        if ((have && bus.mem_addr != held) || bus.mem_wren) bad++;
        held = bus.mem_addr;
        have = 1'b1;
      end else begin
        have = 1'b0;
      end
      @(posedge clk); #1; n++;
    end
    bus.cpu_req = 1'b0;
    ack_delay = 0;
    check_eq("hold_resp", 64'(resp_cnt != start), 64'd1);
    check_eq("hold_stable", 64'(bad), 64'd0);
    check_eq("hold_ready_low", 64'(ready_bad), 64'd0);
    check_eq("hold_stretched", 64'(n >= 40), 64'd1);

    repeat (3) @(posedge clk); #1;
    check_counters();

    // reset during word 2 of a refill
    push_exp(1'b0, 12'h7C5, 32'h0, 1'b0, 32'h0000_07C5);
    issue(1'b0, 12'h7C5, 32'h0);
    n = 0;
    while (!(bus.mem_req && bus.mem_addr == 12'h7C6) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check_eq("reach_word2", 64'(bus.mem_addr), 64'h7C6);
    rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    exp_mem_q.delete();
    exp_resp_q.delete();
    exp_hits = 0; exp_misses = 0; exp_dout = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("ready_after_midrst", 64'(bus.cpu_ready), 64'd1);

    do_access(1'b0, 12'h7C5, 32'h0, 1'b0, 32'h0000_07C5);
    do_access(1'b0, 12'hABC, 32'h0, 1'b0, 32'h0000_0ABC);
    do_access(1'b0, 12'h7C5, 32'h0, 1'b1, 32'h0000_07C5);

    repeat (4) @(posedge clk); #1;
    check_counters();
    check_eq("resp_q_empty", 64'(exp_resp_q.size()), 64'd0);
    check_eq("mem_q_empty", 64'(exp_mem_q.size()), 64'd0);
    check_eq("req_gap", 64'(gap_bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
